// File: rtl/regfile_sb.sv
// Parametrised IITB-RISC register file: two combinational read ports, one writeback port,
// a dedicated PC port and a per-register pending-write scoreboard for RAW hazard detection.
module regfile_sb #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned PEND_W  = 2,
    parameter bit          ZERO_R0 = 1'b0,
    parameter bit          BYPASS  = 1'b1,
    parameter int unsigned PC_REG  = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [ADDR_W-1:0]       rd_addr_a,
    output logic [DATA_W-1:0]       rd_data_a,
    output logic                    rd_pend_a,
    input  logic [ADDR_W-1:0]       rd_addr_b,
    output logic [DATA_W-1:0]       rd_data_b,
    output logic                    rd_pend_b,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_addr,
    output logic                    iss_full,
    input  logic                    pc_wr_en,
    input  logic [DATA_W-1:0]       pc_wr_data,
    output logic [DATA_W-1:0]       pc_out,
    output logic [(2**ADDR_W)-1:0]  pend_vec
);

    localparam int unsigned       DEPTH   = 2**ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);
    localparam logic [ADDR_W-1:0] PC_IDX  = ADDR_W'(PC_REG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PEND_W-1:0] cnt [DEPTH];

    logic              wr_ok;
    logic              wr_to_pc;
    logic              pc_wr_go;
    logic [DEPTH-1:0]  inc;
    logic [DEPTH-1:0]  dec;

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_pend [2];

    assign wr_ok    = wr_en && !(ZERO_R0 && (wr_addr == '0));
    assign wr_to_pc = wr_en && (wr_addr == PC_IDX);
    assign pc_wr_go = pc_wr_en && !wr_to_pc;

    // Register array; writeback data wins over the PC port on a collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pc_wr_go) mem[PC_IDX] <= pc_wr_data;
            if (wr_ok)    mem[wr_addr] <= wr_data;
        end
    end

    assign iss_full = (cnt[iss_addr] == CNT_MAX) && !(ZERO_R0 && (iss_addr == '0));

    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            inc[i] = iss_en && (iss_addr == ADDR_W'(i)) && !iss_full && !(ZERO_R0 && (i == 0));
            dec[i] = wr_en && (wr_addr == ADDR_W'(i)) && (cnt[i] != '0);
        end
    end

    // Pending counters: simultaneous issue and retire cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (inc[i] && !dec[i])      cnt[i] <= cnt[i] + CNT_ONE;
                else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - CNT_ONE;
            end
        end
    end

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    // Read ports with optional forwarding from this cycle's writeback or PC update
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = mem[rd_addr[p]];
            rd_pend[p] = (cnt[rd_addr[p]] != '0);
            if (ZERO_R0 && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
            end else if (BYPASS && wr_ok && (wr_addr == rd_addr[p])) begin
                rd_data[p] = wr_data;
            end else if (BYPASS && (rd_addr[p] == PC_IDX) && pc_wr_en && !wr_to_pc) begin
                rd_data[p] = pc_wr_data;
            end
            if (BYPASS && (cnt[rd_addr[p]] == CNT_ONE) && wr_en && (wr_addr == rd_addr[p])) begin
                rd_pend[p] = 1'b0;
            end
        end
    end

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];
    assign rd_pend_a = rd_pend[0];
    assign rd_pend_b = rd_pend[1];
    assign pc_out    = mem[PC_IDX];

    always_comb begin
        pend_vec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) pend_vec[i] = (cnt[i] != '0);
    end

endmodule
